// File: rtl/axi_ddr3_rd_arbiter.sv
// Two-port AXI4 read arbiter for the axi_ddr3_lite read port: round-robin AR grant, port-tagged IDs, R steering.
// Optional ARB_FIXED_PRIORITY_EN: port 0 gets strict priority over port 1.
module axi_ddr3_rd_arbiter #(
  parameter int unsigned ADDRS       = 23,
  parameter int unsigned REQID       = 4,
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MAX_PENDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               s0_arvalid_i,
  output logic               s0_arready_o,
  input  logic [ADDRS-1:0]   s0_araddr_i,
  input  logic [REQID-1:0]   s0_arid_i,
  input  logic [7:0]         s0_arlen_i,
  input  logic [1:0]         s0_arburst_i,
  input  logic               s1_arvalid_i,
  output logic               s1_arready_o,
  input  logic [ADDRS-1:0]   s1_araddr_i,
  input  logic [REQID-1:0]   s1_arid_i,
  input  logic [7:0]         s1_arlen_i,
  input  logic [1:0]         s1_arburst_i,
  output logic               s0_rvalid_o,
  input  logic               s0_rready_i,
  output logic               s0_rlast_o,
  output logic [1:0]         s0_rresp_o,
  output logic [REQID-1:0]   s0_rid_o,
  output logic [WIDTH-1:0]   s0_rdata_o,
  output logic               s1_rvalid_o,
  input  logic               s1_rready_i,
  output logic               s1_rlast_o,
  output logic [1:0]         s1_rresp_o,
  output logic [REQID-1:0]   s1_rid_o,
  output logic [WIDTH-1:0]   s1_rdata_o,
  output logic               m_arvalid_o,
  input  logic               m_arready_i,
  output logic [ADDRS-1:0]   m_araddr_o,
  output logic [REQID:0]     m_arid_o,
  output logic [7:0]         m_arlen_o,
  output logic [1:0]         m_arburst_o,
  input  logic               m_rvalid_i,
  output logic               m_rready_o,
  input  logic               m_rlast_i,
  input  logic [1:0]         m_rresp_i,
  input  logic [REQID:0]     m_rid_i,
  input  logic [WIDTH-1:0]   m_rdata_i
);

  localparam int unsigned CW = $clog2(MAX_PENDING + 1);

  logic [CW-1:0] pending;
  logic          load;
  logic          grant0;
  logic          grant1;
  logic          accept;
  logic          rd_done;
  logic          port;

  // The AR register may reload when empty or draining, and only while the controller queue has room.
  assign load    = (~m_arvalid_o | m_arready_i) & (pending < CW'(MAX_PENDING));
  assign accept  = load & (grant0 | grant1);
  assign rd_done = m_rvalid_i & m_rready_o & m_rlast_i;

  assign s0_arready_o = load & grant0;
  assign s1_arready_o = load & grant1;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    grant0 = s0_arvalid_i;
    grant1 = ~s0_arvalid_i & s1_arvalid_i;
  end
`else
  logic last_grant;

  // On contention the port that did not win last time gets the grant.
  always_comb begin
    grant0 = s0_arvalid_i;
    grant1 = s1_arvalid_i;
    if (s0_arvalid_i && s1_arvalid_i) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`endif

  // A stray rlast with nothing outstanding must not wrap the counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pending <= '0;
    end else begin
      unique case ({accept, rd_done && (pending != '0)})
        2'b10:   pending <= pending + CW'(1);
        2'b01:   pending <= pending - CW'(1);
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      m_arvalid_o <= 1'b0;
      m_araddr_o  <= '0;
      m_arid_o    <= '0;
      m_arlen_o   <= '0;
      m_arburst_o <= '0;
    end else if (accept) begin
      m_arvalid_o <= 1'b1;
      m_araddr_o  <= grant1 ? s1_araddr_i : s0_araddr_i;
      m_arid_o    <= grant1 ? {1'b1, s1_arid_i} : {1'b0, s0_arid_i};
      m_arlen_o   <= grant1 ? s1_arlen_i : s0_arlen_i;
      m_arburst_o <= grant1 ? s1_arburst_i : s0_arburst_i;
    end else if (m_arready_i) begin
      m_arvalid_o <= 1'b0;
    end
  end

  // R beats are steered by the port bit carried in the ID MSB.
  assign port        = m_rid_i[REQID];
  assign s0_rvalid_o = m_rvalid_i & ~port;
  assign s1_rvalid_o = m_rvalid_i & port;
  assign m_rready_o  = port ? s1_rready_i : s0_rready_i;

  assign s0_rid_o   = m_rid_i[REQID-1:0];
  assign s1_rid_o   = m_rid_i[REQID-1:0];
  assign s0_rdata_o = m_rdata_i;
  assign s1_rdata_o = m_rdata_i;
  assign s0_rresp_o = m_rresp_i;
  assign s1_rresp_o = m_rresp_i;
  assign s0_rlast_o = m_rlast_i;
  assign s1_rlast_o = m_rlast_i;

endmodule

// File: tb/tb_axi_ddr3_rd_arbiter.sv
// Directed bench for axi_ddr3_rd_arbiter (default round-robin build, MAX_PENDING = 4).
module tb_axi_ddr3_rd_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        s0_arvalid_i, s1_arvalid_i;
  logic        s0_arready_o, s1_arready_o;
  logic [22:0] s0_araddr_i, s1_araddr_i;
  logic [3:0]  s0_arid_i, s1_arid_i;
  logic [7:0]  s0_arlen_i, s1_arlen_i;
  logic [1:0]  s0_arburst_i, s1_arburst_i;
  logic        s0_rvalid_o, s1_rvalid_o;
  logic        s0_rready_i, s1_rready_i;
  logic        s0_rlast_o, s1_rlast_o;
  logic [1:0]  s0_rresp_o, s1_rresp_o;
  logic [3:0]  s0_rid_o, s1_rid_o;
  logic [31:0] s0_rdata_o, s1_rdata_o;
  logic        m_arvalid_o, m_arready_i;
  logic [22:0] m_araddr_o;
  logic [4:0]  m_arid_o;
  logic [7:0]  m_arlen_o;
  logic [1:0]  m_arburst_o;
  logic        m_rvalid_i, m_rready_o, m_rlast_i;
  logic [1:0]  m_rresp_i;
  logic [4:0]  m_rid_i;
  logic [31:0] m_rdata_i;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  axi_ddr3_rd_arbiter dut (
    .clock(clock), .reset(reset),
    .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o), .s0_araddr_i(s0_araddr_i),
    .s0_arid_i(s0_arid_i), .s0_arlen_i(s0_arlen_i), .s0_arburst_i(s0_arburst_i),
    .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o), .s1_araddr_i(s1_araddr_i),
    .s1_arid_i(s1_arid_i), .s1_arlen_i(s1_arlen_i), .s1_arburst_i(s1_arburst_i),
    .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i), .s0_rlast_o(s0_rlast_o),
    .s0_rresp_o(s0_rresp_o), .s0_rid_o(s0_rid_o), .s0_rdata_o(s0_rdata_o),
    .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i), .s1_rlast_o(s1_rlast_o),
    .s1_rresp_o(s1_rresp_o), .s1_rid_o(s1_rid_o), .s1_rdata_o(s1_rdata_o),
    .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i), .m_araddr_o(m_araddr_o),
    .m_arid_o(m_arid_o), .m_arlen_o(m_arlen_o), .m_arburst_o(m_arburst_o),
    .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o), .m_rlast_i(m_rlast_i),
    .m_rresp_i(m_rresp_i), .m_rid_i(m_rid_i), .m_rdata_i(m_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic r_beat(input logic valid, input logic [4:0] rid, input logic last);
    m_rvalid_i = valid;
    m_rid_i    = rid;
    m_rlast_i  = last;
  endtask

  initial begin
    reset = 1'b1;
    s0_arvalid_i = 1'b0; s0_araddr_i = '0; s0_arid_i = '0; s0_arlen_i = '0; s0_arburst_i = '0;
    s1_arvalid_i = 1'b0; s1_araddr_i = '0; s1_arid_i = '0; s1_arlen_i = '0; s1_arburst_i = '0;
    s0_rready_i = 1'b1; s1_rready_i = 1'b1;
    m_arready_i = 1'b1;
    m_rvalid_i = 1'b0; m_rlast_i = 1'b0; m_rresp_i = '0; m_rid_i = '0; m_rdata_i = '0;

    // Reset state
    tick(); tick();
    check("rst_arvalid", 64'(m_arvalid_o), 64'd0);
    check("rst_s0_arready", 64'(s0_arready_o), 64'd0);
    check("rst_s1_arready", 64'(s1_arready_o), 64'd0);
    reset = 1'b0;
    tick();

    // Single port 0 read, 4 beats
    s0_arvalid_i = 1'b1; s0_araddr_i = 23'h10; s0_arid_i = 4'h3; s0_arlen_i = 8'd3; s0_arburst_i = 2'd1;
    #1;
    check("t1_s0_arready", 64'(s0_arready_o), 64'd1);
    check("t1_s1_arready", 64'(s1_arready_o), 64'd0);
    tick();
    check("t1_arvalid", 64'(m_arvalid_o), 64'd1);
    check("t1_arid", 64'(m_arid_o), 64'h03);
    check("t1_araddr", 64'(m_araddr_o), 64'h10);
    check("t1_arlen", 64'(m_arlen_o), 64'd3);
    check("t1_arburst", 64'(m_arburst_o), 64'd1);
    s0_arvalid_i = 1'b0;
    tick();
    check("t1_arvalid_clr", 64'(m_arvalid_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      r_beat(1'b1, 5'h03, i == 3);
      m_rdata_i = 32'hA0 + 32'(i);
      #1;
      check("t1_s0_rvalid", 64'(s0_rvalid_o), 64'd1);
      check("t1_s1_rvalid", 64'(s1_rvalid_o), 64'd0);
      check("t1_m_rready", 64'(m_rready_o), 64'd1);
      check("t1_s0_rlast", 64'(s0_rlast_o), 64'(i == 3));
      check("t1_s0_rid", 64'(s0_rid_o), 64'h3);
      check("t1_s0_rdata", 64'(s0_rdata_o), 64'hA0 + 64'(i));
      tick();
    end
    r_beat(1'b0, 5'h00, 1'b0);

    // Both ports contend; last grant was port 0 so port 1 leads. rlast each cycle keeps the count low.
    s0_arvalid_i = 1'b1; s0_arid_i = 4'h2;
    s1_arvalid_i = 1'b1; s1_arid_i = 4'h7;
    r_beat(1'b1, 5'h00, 1'b1);
    for (int k = 0; k < 8; k++) begin
      #1;
      check("t2_s0_arready", 64'(s0_arready_o), 64'(k % 2 == 1));
      check("t2_s1_arready", 64'(s1_arready_o), 64'(k % 2 == 0));
      tick();
      check("t2_arid", 64'(m_arid_o), (k % 2 == 0) ? 64'h17 : 64'h02);
      check("t2_arvalid", 64'(m_arvalid_o), 64'd1);
    end
    s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0;
    tick();
    r_beat(1'b0, 5'h00, 1'b0);

    // Pending cap: 4 accepts, then stall; rlast frees a slot; accept with rlast keeps count.
    s0_arvalid_i = 1'b1; s0_araddr_i = 23'h100;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t3_fill_arready", 64'(s0_arready_o), 64'd1);
      tick();
    end
    #1;
    check("t3_full_a", 64'(s0_arready_o), 64'd0);
    tick();
    #1;
    check("t3_full_b", 64'(s0_arready_o), 64'd0);
    r_beat(1'b1, 5'h00, 1'b1);
    #1;
    check("t3_full_rlast", 64'(s0_arready_o), 64'd0);
    check("t3_m_rready", 64'(m_rready_o), 64'd1);
    tick();
    r_beat(1'b0, 5'h00, 1'b0);
    #1;
    check("t3_freed", 64'(s0_arready_o), 64'd1);
    tick();
    #1;
    check("t3_refull", 64'(s0_arready_o), 64'd0);
    r_beat(1'b1, 5'h00, 1'b1);
    tick();
    #1;
    check("t3_both_arready", 64'(s0_arready_o), 64'd1);
    tick();
    r_beat(1'b0, 5'h00, 1'b0);
    #1;
    check("t3_after_both", 64'(s0_arready_o), 64'd1);
    tick();
    #1;
    check("t3_full_end", 64'(s0_arready_o), 64'd0);
    s0_arvalid_i = 1'b0;
    r_beat(1'b1, 5'h00, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    r_beat(1'b0, 5'h00, 1'b0);

    // Controller stalls AR for 5 cycles: payload must hold.
    m_arready_i = 1'b0;
    s1_arvalid_i = 1'b1; s1_araddr_i = 23'h1234; s1_arid_i = 4'h5; s1_arlen_i = 8'd7; s1_arburst_i = 2'd2;
    #1;
    check("t4_s1_arready", 64'(s1_arready_o), 64'd1);
    check("t4_s0_arready", 64'(s0_arready_o), 64'd0);
    tick();
    check("t4_arvalid", 64'(m_arvalid_o), 64'd1);
    check("t4_arid", 64'(m_arid_o), 64'h15);
    check("t4_arlen", 64'(m_arlen_o), 64'd7);
    check("t4_arburst", 64'(m_arburst_o), 64'd2);
    s1_araddr_i = 23'h2222; s1_arid_i = 4'h6;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t4_stall_arready", 64'(s1_arready_o), 64'd0);
      check("t4_stall_araddr", 64'(m_araddr_o), 64'h1234);
      check("t4_stall_arid", 64'(m_arid_o), 64'h15);
      check("t4_stall_arvalid", 64'(m_arvalid_o), 64'd1);
      tick();
    end
    m_arready_i = 1'b1;
    #1;
    check("t4_release", 64'(s1_arready_o), 64'd1);
    tick();
    check("t4_next_araddr", 64'(m_araddr_o), 64'h2222);
    check("t4_next_arid", 64'(m_arid_o), 64'h16);
    s1_arvalid_i = 1'b0;
    tick();

    // R backpressure on port 1, then drain both outstanding bursts.
    r_beat(1'b1, 5'h15, 1'b1);
    m_rdata_i = 32'hDEADBEEF; m_rresp_i = 2'd2;
    s1_rready_i = 1'b0; s0_rready_i = 1'b1;
    #1;
    check("t5_s1_rvalid", 64'(s1_rvalid_o), 64'd1);
    check("t5_s0_rvalid", 64'(s0_rvalid_o), 64'd0);
    check("t5_m_rready", 64'(m_rready_o), 64'd0);
    check("t5_s1_rid", 64'(s1_rid_o), 64'h5);
    check("t5_s1_rdata", 64'(s1_rdata_o), 64'hDEADBEEF);
    check("t5_s1_rresp", 64'(s1_rresp_o), 64'd2);
    tick();
    s1_rready_i = 1'b1;
    #1;
    check("t5_m_rready_go", 64'(m_rready_o), 64'd1);
    tick();
    r_beat(1'b1, 5'h03, 1'b1);
    m_rresp_i = 2'd0;
    #1;
    check("t5_p0_rvalid", 64'(s0_rvalid_o), 64'd1);
    check("t5_p0_s1_rvalid", 64'(s1_rvalid_o), 64'd0);
    tick();
    r_beat(1'b0, 5'h00, 1'b0);

    // Reset in the middle of a burst.
    m_arready_i = 1'b0;
    s0_arvalid_i = 1'b1; s0_araddr_i = 23'h40; s0_arid_i = 4'h3; s0_arlen_i = 8'd3;
    tick();
    s0_arvalid_i = 1'b0;
    r_beat(1'b1, 5'h03, 1'b0);
    tick(); tick();
    r_beat(1'b0, 5'h00, 1'b0);
    reset = 1'b1;
    tick();
    check("t6_arvalid", 64'(m_arvalid_o), 64'd0);
    check("t6_s0_arready", 64'(s0_arready_o), 64'd0);
    check("t6_s1_arready", 64'(s1_arready_o), 64'd0);
    reset = 1'b0;
    m_arready_i = 1'b1;
    s0_arvalid_i = 1'b1; s1_arvalid_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_s0_arready_rr", 64'(s0_arready_o), 64'(k % 2 == 0));
      check("t6_s1_arready_rr", 64'(s1_arready_o), 64'(k % 2 == 1));
      tick();
    end
    #1;
    check("t6_cap_s0", 64'(s0_arready_o), 64'd0);
    check("t6_cap_s1", 64'(s1_arready_o), 64'd0);
    s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_ddr3_rd_arbiter.md
Name: axi_ddr3_rd_arbiter

Overview:
- Two-port AXI4 read-channel arbiter that shares the single read port of axi_ddr3_lite (AR/R channels) between two requesters, e.g. a CPU and a video fetcher.
- Registers and round-robins read-address requests, tags each with a port bit in the ID, and steers R beats back to the owning port.
- Caps in-flight bursts so the controller's read queue never overflows.

Parameters:
- ADDRS, 23, burst-aligned address width (byte address bits [26:4]); ASB = ADDRS-1.
- REQID, 4, per-port AXI ID width; ISB = REQID-1. Downstream ID width is REQID+1.
- WIDTH, 32, read-data width; MSB = WIDTH-1.
- MAX_PENDING, 4, maximum accepted-but-unfinished bursts (1..15).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s0_arvalid_i / s1_arvalid_i  in  1  port AR valid
- s0_arready_o / s1_arready_o  out  1  port AR ready
- s0_araddr_i / s1_araddr_i  in  ADDRS  port AR address
- s0_arid_i / s1_arid_i  in  REQID  port AR ID
- s0_arlen_i / s1_arlen_i  in  8  port AR length
- s0_arburst_i / s1_arburst_i  in  2  port AR burst type
- s0_rvalid_o / s1_rvalid_o  out  1  port R valid
- s0_rready_i / s1_rready_i  in  1  port R ready
- s0_rlast_o / s1_rlast_o  out  1  port R last
- s0_rresp_o / s1_rresp_o  out  2  port R response
- s0_rid_o / s1_rid_o  out  REQID  port R ID
- s0_rdata_o / s1_rdata_o  out  WIDTH  port R data
- m_arvalid_o  out  1  controller AR valid
- m_arready_i  in  1  controller AR ready
- m_araddr_o  out  ADDRS  controller AR address
- m_arid_o  out  REQID+1  controller AR ID
- m_arlen_o  out  8  controller AR length
- m_arburst_o  out  2  controller AR burst type
- m_rvalid_i  in  1  controller R valid
- m_rready_o  out  1  controller R ready
- m_rlast_i  in  1  controller R last
- m_rresp_i  in  2  controller R response
- m_rid_i  in  REQID+1  controller R ID
- m_rdata_i  in  WIDTH  controller R data

Behaviour:
- Reset:
  - m_arvalid_o=0; s0/s1_arready_o=0; pending count=0.
  - Round-robin pointer = "last granted port 1", so port 0 wins first.
  - R outputs are combinational and follow the rules below (rvalid=0 whenever m_rvalid_i=0).
- AR stage:
  - One output register holds {addr, id, len, burst}.
  - load = (~m_arvalid_o | m_arready_i) & (pending < MAX_PENDING).
- Grant (combinational, same cycle):
  - One requester: that port.
  - Both requesting: the port not granted last.
  - sN_arready_o = load & grantN.
  - Pointer updates only on an accepted request.
- On sN handshake:
  - Register captures port N fields.
  - m_arid_o = {N, sN_arid_i}.
  - m_arvalid_o=1 on the next cycle, so latency is 1 cycle.
  - Back-to-back accepts at full rate while m_arready_i=1.
- If load=0: m_arvalid_o and its fields hold stable until m_arready_i (AXI stability rule).
- Pending counter:
  - +1 on a port AR handshake; -1 on m_rvalid_i & m_rready_o & m_rlast_i.
  - Both in the same cycle: unchanged.
  - Saturated at MAX_PENDING: both arready_o low.
  - The counter never underflows; a stray rlast at count 0 is ignored.
- R routing (combinational, zero latency):
  - p = m_rid_i[REQID].
  - sp_rvalid_o = m_rvalid_i; the other port's rvalid_o = 0.
  - m_rready_o = sp_rready_i.
  - rid = m_rid_i[ISB:0]; rdata/rresp/rlast broadcast to both ports.
- Interleaving across ports is permitted and is per controller order. The arbiter does not reorder.
- Reset mid-burst: all state cleared next edge. Outstanding bursts are abandoned; the controller is reset by the same signal.

Optional Feature:
- Macro: ARB_FIXED_PRIORITY_EN.
- Defined: port 0 has strict priority; port 1 is granted only when s0_arvalid_i=0. The pointer is unused.
- Undefined: fair round-robin as above.

Test Plan:
- Single port 0 read: addr=0x10, id=3, len=3 -> m_arid=0x03 one cycle later; 4 R beats with m_rid=0x03 appear only on s0, s0_rlast on beat 4; pending returns to 0.
- Both ports assert together for 4 requests each, m_arready=1 -> grants alternate s0,s1,s0,s1...; m_arid MSB toggles each cycle.
- MAX_PENDING=4, no R traffic -> exactly 4 accepts, then both arready low. One rlast then frees one slot; a simultaneous new accept leaves the count at 4.
- m_arready held low 5 cycles with a request registered -> m_araddr/m_arid stable and no new arready until the handshake.
- R beat with m_rid=0x15 and s1_rready=0 -> s1_rvalid=1, s0_rvalid=0, m_rready=0 (backpressure); s1_rid=0x5.
- Assert reset during a 4-beat burst -> next cycle m_arvalid=0, arready=0, count=0; first request after reset goes to port 0 when both request.
